// File: rtl/uart_pkg.sv
// Shared UART definitions: character width and the tx-side FIFO drain states.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_ACT  = 2'd2,
        WAIT_IDLE = 2'd3
    } tx_fifo_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer write handshake plus the uart_tx hookup and status of uart_tx_fifo.
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = UART_DATA_W,
    parameter int unsigned DEPTH  = 16
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] wr_data_i;
    logic              wr_valid_i;
    logic              wr_ready_o;
    logic              tx_start_o;
    logic [DATA_W-1:0] tx_data_o;
    logic              tx_active_i;
    logic              tx_done_i;
    logic [ADDR_W:0]   level_o;
    logic              empty_o;
    logic              full_o;
    logic [15:0]       sent_cnt_o;

    modport master (
        output wr_data_i, wr_valid_i, tx_active_i, tx_done_i,
        input  wr_ready_o, tx_start_o, tx_data_o, level_o, empty_o, full_o, sent_cnt_o
    );

    modport slave (
        input  wr_data_i, wr_valid_i, tx_active_i, tx_done_i,
        output wr_ready_o, tx_start_o, tx_data_o, level_o, empty_o, full_o, sent_cnt_o
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Circular synchronous FIFO: storage, wrapping pointers and registered level/flags.
module uart_sync_fifo #(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data_c,
    output logic [LVL_W-1:0]  level,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [LVL_W-1:0]  level_nxt;
    logic              do_push;
    logic              do_pop;

    // A full FIFO refuses writes even if a pop lands in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        level_nxt = level;
        if (do_push && !do_pop) begin
            level_nxt = level + LVL_W'(1);
        end else if (!do_push && do_pop) begin
            level_nxt = level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            level <= level_nxt;
            empty <= (level_nxt == LVL_W'(0));
            full  <= (level_nxt == LVL_W'(DEPTH));
        end
    end

    // Storage is not reset; stale entries are unreachable through the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers producer bytes and feeds them to uart_tx one start pulse at a time.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned DATA_W = UART_DATA_W,
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input logic           clk,
    input logic           resetn,
    uart_tx_fifo_if.slave bus
);

    tx_fifo_state_e    state;
    tx_fifo_state_e    state_nxt;
    logic              tx_start;
    logic              tx_start_nxt;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] tx_data_nxt;
    logic [15:0]       sent_cnt;
    logic [15:0]       sent_cnt_nxt;
    logic              pop;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   level;
    logic              empty;
    logic              full;
    logic              unused_done;

    // Completion is taken from the falling edge of active, not from done.
    assign unused_done = bus.tx_done_i;

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (bus.wr_valid_i),
        .wr_data   (bus.wr_data_i),
        .pop       (pop),
        .rd_data_c (rd_data),
        .level     (level),
        .empty     (empty),
        .full      (full)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            sent_cnt <= '0;
        end else begin
            state    <= state_nxt;
            tx_start <= tx_start_nxt;
            tx_data  <= tx_data_nxt;
            sent_cnt <= sent_cnt_nxt;
        end
    end

    // LAUNCH pops the head byte and registers start/data together for one cycle.
    always_comb begin
        state_nxt    = state;
        tx_start_nxt = 1'b0;
        tx_data_nxt  = tx_data;
        sent_cnt_nxt = sent_cnt;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !bus.tx_active_i) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                pop          = 1'b1;
                tx_start_nxt = 1'b1;
                tx_data_nxt  = rd_data;
                sent_cnt_nxt = sent_cnt + 16'd1;
                state_nxt    = WAIT_ACT;
            end
            WAIT_ACT: begin
                if (bus.tx_active_i) state_nxt = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (!bus.tx_active_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.wr_ready_o = ~full;
    assign bus.tx_start_o = tx_start;
    assign bus.tx_data_o  = tx_data;
    assign bus.level_o    = level;
    assign bus.empty_o    = empty;
    assign bus.full_o     = full;
    assign bus.sent_cnt_o = sent_cnt;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: behavioural uart_tx model plus byte scoreboard.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;

    typedef struct {
        logic [7:0] data;
        int         level;
        int         full;
        int         ready;
    } vec_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // uart_tx stand-in: start raises active for 3..20 cycles; stall forces active high.
    logic stall        = 1'b0;
    logic model_active = 1'b0;
    logic model_done   = 1'b0;
    int   model_cnt    = 0;

    assign bus.tx_active_i = model_active | stall;
    assign bus.tx_done_i   = model_done;

    always @(posedge clk) begin
        model_done <= 1'b0;
        if (model_cnt > 1) begin
            model_cnt <= model_cnt - 1;
        end else if (model_cnt == 1) begin
            model_cnt    <= 0;
            model_active <= 1'b0;
            model_done   <= 1'b1;
        end else if (bus.tx_start_o) begin
            model_active <= 1'b1;
            model_cnt    <= int'($urandom_range(20, 3));
        end
    end

    int         checks    = 0;
    int         failures  = 0;
    int         start_cnt = 0;
    int         pops      = 0;
    logic       prev_start = 1'b0;
    logic [7:0] exp_q[$];
    vec_t       vecs[16];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        int ok;
        ok = 0;
        @(posedge clk);
        #1;
        bus.wr_data_i  = d;
        bus.wr_valid_i = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.wr_ready_o === 1'b1) begin
                @(posedge clk);
                exp_q.push_back(d);
                ok = 1;
                break;
            end
        end
        #1;
        bus.wr_valid_i = 1'b0;
        check("push_timeout", ok, 1);
    endtask

    task automatic wait_drain();
        int ok;
        int streak;
        ok     = 0;
        streak = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.empty_o && !bus.tx_active_i && !bus.tx_start_o)
                streak++;
            else
                streak = 0;
            if (streak >= 3) begin
                ok = 1;
                break;
            end
        end
        check("drain_timeout", ok, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s0;
        int ok;
        bus.wr_valid_i = 1'b0;
        bus.wr_data_i  = '0;

        // Scoreboard: every start pulse must carry the oldest accepted byte.
        fork
            forever begin
                @(negedge clk);
                if (resetn) begin
                    check("level_bound", int'(bus.level_o <= 5'(DEPTH)), 1);
                    if (bus.tx_start_o) begin
                        start_cnt++;
                        pops++;
                        check("start_one_cycle", int'(prev_start), 0);
                        check("sb_has_entry", int'(exp_q.size() != 0), 1);
                        if (exp_q.size() != 0)
                            check("tx_data_order", int'(bus.tx_data_o), int'(exp_q.pop_front()));
                    end
                end
                prev_start = bus.tx_start_o;
            end
        join_none

        // Reset values
        #12;
        check("rst_level", int'(bus.level_o), 0);
        check("rst_empty", int'(bus.empty_o), 1);
        check("rst_full", int'(bus.full_o), 0);
        check("rst_ready", int'(bus.wr_ready_o), 1);
        check("rst_start", int'(bus.tx_start_o), 0);
        check("rst_data", int'(bus.tx_data_o), 0);
        check("rst_sent", int'(bus.sent_cnt_o), 0);
        #6 resetn = 1'b1;

        // Single byte latency: start two cycles after the push edge, one cycle wide
        push_byte(8'hA5);
        @(negedge clk);
        check("single_start_p0", int'(bus.tx_start_o), 0);
        check("single_level", int'(bus.level_o), 1);
        @(negedge clk);
        check("single_start_p1", int'(bus.tx_start_o), 0);
        @(negedge clk);
        check("single_start_p2", int'(bus.tx_start_o), 1);
        check("single_data", int'(bus.tx_data_o), 'hA5);
        check("single_sent", int'(bus.sent_cnt_o), 1);
        check("single_empty", int'(bus.empty_o), 1);
        @(negedge clk);
        check("single_start_p3", int'(bus.tx_start_o), 0);
        check("single_data_hold", int'(bus.tx_data_o), 'hA5);
        wait_drain();

        // Fill to full with the transmitter stalled, table-driven
        for (int i = 0; i < 16; i++) begin
            vecs[i].data  = 8'(i);
            vecs[i].level = i + 1;
            vecs[i].full  = (i == 15) ? 1 : 0;
            vecs[i].ready = (i == 15) ? 0 : 1;
        end
        stall = 1'b1;
        s0 = start_cnt;
        for (int i = 0; i < 16; i++) begin
            push_byte(vecs[i].data);
            @(negedge clk);
            check("fill_level", int'(bus.level_o), vecs[i].level);
            check("fill_full", int'(bus.full_o), vecs[i].full);
            check("fill_ready", int'(bus.wr_ready_o), vecs[i].ready);
        end
        @(posedge clk);
        #1;
        bus.wr_data_i  = 8'hEE;
        bus.wr_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("full_ignore_level", int'(bus.level_o), 16);
            check("full_ignore_full", int'(bus.full_o), 1);
        end
        @(posedge clk);
        #1;
        bus.wr_valid_i = 1'b0;
        check("full_no_start", start_cnt - s0, 0);
        stall = 1'b0;
        wait_drain();
        check("fill_starts", start_cnt - s0, 16);
        check("fill_sent", int'(bus.sent_cnt_o), 17);

        // Pointer wrap: 40 random bytes against random transmit times
        s0 = start_cnt;
        for (int i = 0; i < 40; i++) begin
            push_byte(8'($urandom));
            repeat ($urandom_range(3, 0)) @(posedge clk);
        end
        wait_drain();
        check("wrap_starts", start_cnt - s0, 40);
        check("wrap_sent", int'(bus.sent_cnt_o), pops);

        // Push landing in the LAUNCH cycle keeps the level constant
        stall = 1'b1;
        push_byte(8'h31);
        push_byte(8'h32);
        push_byte(8'h33);
        @(negedge clk);
        check("simul_pre_level", int'(bus.level_o), 3);
        @(posedge clk);
        #1 stall = 1'b0;
        @(posedge clk);
        #1;
        bus.wr_data_i  = 8'h55;
        bus.wr_valid_i = 1'b1;
        @(posedge clk);
        exp_q.push_back(8'h55);
        #1 bus.wr_valid_i = 1'b0;
        @(negedge clk);
        check("simul_level", int'(bus.level_o), 3);
        check("simul_start", int'(bus.tx_start_o), 1);
        check("simul_data", int'(bus.tx_data_o), 'h31);
        wait_drain();

        // Transmitter already busy when the byte arrives
        stall = 1'b1;
        push_byte(8'h11);
        s0 = start_cnt;
        repeat (6) @(negedge clk);
        check("busy_no_start", start_cnt - s0, 0);
        @(posedge clk);
        #1 stall = 1'b0;
        @(negedge clk);
        check("busy_start_q0", int'(bus.tx_start_o), 0);
        @(negedge clk);
        check("busy_start_q1", int'(bus.tx_start_o), 0);
        @(negedge clk);
        check("busy_start_q2", int'(bus.tx_start_o), 1);
        check("busy_data", int'(bus.tx_data_o), 'h11);
        wait_drain();

        // Asynchronous reset while waiting on the transmitter with bytes buffered
        push_byte(8'h60);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.tx_start_o) begin
                ok = 1;
                break;
            end
        end
        check("rstmid_launch_seen", ok, 1);
        @(posedge clk);
        #1 stall = 1'b1;
        for (int i = 1; i <= 5; i++) push_byte(8'(8'h60 + i));
        @(negedge clk);
        check("rstmid_level", int'(bus.level_o), 5);
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        check("rstmid_level0", int'(bus.level_o), 0);
        check("rstmid_empty", int'(bus.empty_o), 1);
        check("rstmid_full", int'(bus.full_o), 0);
        check("rstmid_ready", int'(bus.wr_ready_o), 1);
        check("rstmid_start", int'(bus.tx_start_o), 0);
        check("rstmid_data", int'(bus.tx_data_o), 0);
        check("rstmid_sent", int'(bus.sent_cnt_o), 0);
        exp_q.delete();
        pops = 0;
        #2 resetn = 1'b1;
        stall = 1'b0;
        s0 = start_cnt;
        repeat (40) @(negedge clk);
        check("rstmid_no_start", start_cnt - s0, 0);
        check("rstmid_post_level", int'(bus.level_o), 0);
        check("rstmid_post_sent", int'(bus.sent_cnt_o), pops);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side buffer sitting directly upstream of uart_tx.
- Accepts bytes from a producer over a valid/ready handshake and stores them in a circular FIFO.
- Drains the FIFO one byte at a time into uart_tx by pulsing start and tracking uart_tx's active flag.
- Lets producers burst bytes without polling transmitter status.

Parameters:
DATA_W, 8, width of one character; must match uart_tx data width
DEPTH, 16, FIFO entries; power of two, at least 2
ADDR_W, $clog2(DEPTH), pointer width (derived; do not override)

Ports:
clk  input  1  system clock; all logic on rising edge
resetn  input  1  asynchronous, active-low reset
wr_data_i  input  DATA_W  byte from producer
wr_valid_i  input  1  producer offers wr_data_i
wr_ready_o  output  1  FIFO can accept; a push occurs when wr_valid_i and wr_ready_o are both high
tx_start_o  output  1  one-cycle start pulse to uart_tx start_i
tx_data_o  output  DATA_W  byte to uart_tx data_to_send_i
tx_active_i  input  1  uart_tx active_o
tx_done_i  input  1  uart_tx done_o; informational only
level_o  output  ADDR_W+1  current occupancy, 0..DEPTH
empty_o  output  1  level_o == 0
full_o  output  1  level_o == DEPTH
sent_cnt_o  output  16  bytes handed to uart_tx since reset; wraps 0xFFFF -> 0

Behaviour:
- Reset (asynchronous, resetn low) sets:
  - wr/rd pointers = 0, level_o = 0, empty_o = 1, full_o = 0, wr_ready_o = 1
  - tx_start_o = 0, tx_data_o = 0, sent_cnt_o = 0, FSM = IDLE
- Reset asserted mid-transmission discards all buffered bytes; the byte already in flight in uart_tx is not recalled.
- wr_ready_o = !full_o, decoded from registered level with no combinational path from wr_valid_i.
- Push:
  - On a handshake, write mem[wr_ptr] and increment wr_ptr modulo DEPTH (natural wrap).
  - A push when full is impossible because ready is low; wr_valid_i while full is ignored with no state change.
- Pop happens only at LAUNCH, as described in the FSM below.
- Simultaneous push and pop in one cycle: level is unchanged, both pointers advance. Legal at any level below DEPTH.
- When full, a same-cycle pop does not enable a push; wr_ready_o follows the registered level.
- FSM states: IDLE, LAUNCH, WAIT_ACT, WAIT_IDLE.
  - IDLE: if !empty_o and !tx_active_i, go to LAUNCH. Otherwise stay.
  - LAUNCH, exactly one cycle:
    - tx_start_o = 1 and tx_data_o <= mem[rd_ptr], both registered so they are valid in the same cycle.
    - rd_ptr++, level--, sent_cnt_o++.
    - Go to WAIT_ACT.
  - WAIT_ACT: tx_start_o = 0. When tx_active_i = 1, go to WAIT_IDLE.
  - WAIT_IDLE: when tx_active_i = 0, go to IDLE.
- tx_data_o holds its value from LAUNCH until the next LAUNCH.
- Latency: a byte pushed into an empty FIFO with the transmitter idle produces tx_start_o high 2 cycles after the push edge (push edge -> IDLE sees !empty -> LAUNCH).
- Inter-byte gap: the next LAUNCH comes no earlier than 1 cycle after tx_active_i falls.
- tx_done_i does not drive transitions; the active-fall is authoritative.
- sent_cnt_o wraps silently.
- Unused FSM encodings return to IDLE.

Decomposition:
- Package uart_pkg holds:
  - the tx_fifo state enumeration (IDLE/LAUNCH/WAIT_ACT/WAIT_IDLE, 2-bit)
  - UART_DATA_W = 8, shared with uart_tx and uart_rx
- One sub-module, uart_sync_fifo:
  - Parameterised storage, pointers and level: push/pop, full/empty/level.
  - Can be reused later on the uart_rx side.
- uart_tx_fifo contains the FSM, the output registers and sent_cnt_o.

Test Plan:
- Single byte: reset, tx model idle, push 0xA5 -> tx_start_o high for exactly 1 cycle, 2 cycles after the push; tx_data_o = 0xA5; sent_cnt_o = 1; empty_o = 1 after LAUNCH.
- Fill to full: stall the tx model (active held high), push 16 bytes 0x00..0x0F -> full_o = 1, wr_ready_o = 0, level_o = 16. A 17th push with valid held is ignored. Release active -> bytes emerge in order 0x00..0x0F, one start pulse per active-fall.
- Pointer wrap: push/drain 40 bytes with a random tx model active time of 3..20 cycles -> output sequence equals input sequence; level_o never exceeds 16 and never underflows.
- Simultaneous push/pop: level 3, push 0x55 in the LAUNCH cycle -> level_o stays 3; 0x55 emitted in order after the prior 3 bytes.
- Busy transmitter at start: tx_active_i already high, push 0x11 -> no tx_start_o until tx_active_i falls, then start pulse next cycle+1.
- Reset mid-operation: 5 bytes buffered, FSM in WAIT_IDLE, pulse resetn low asynchronously (not clock-aligned) -> all outputs at reset values immediately; after release, no tx_start_o occurs without new pushes.
